// File: rtl/irq_controller.sv
// Interrupt controller: synchronises raw pins, captures edges or levels,
// masks/prioritises pending lines and hands one request at a time to the core.
module irq_controller #(
   parameter int unsigned NIRQ = 8,
   parameter int unsigned IDW  = 3
) (
   input  logic            ph1,
   input  logic            reset,
   input  logic [NIRQ-1:0] irq_in,
   input  logic            cfg_we,
   input  logic [1:0]      cfg_addr,
   input  logic [NIRQ-1:0] cfg_wdata,
   output logic [NIRQ-1:0] cfg_rdata,
   output logic            int_req,
   output logic [IDW-1:0]  int_id,
   input  logic            int_ack,
   input  logic            eoi,
   output logic            in_service
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_e;

   localparam logic [1:0] ADDR_ENABLE  = 2'd0;
   localparam logic [1:0] ADDR_PENDING = 2'd1;
   localparam logic [1:0] ADDR_STATUS  = 2'd2;
   localparam logic [1:0] ADDR_MODE    = 2'd3;

   logic [NIRQ-1:0] sync1_q, sync2_q, sync3_q;
   logic [NIRQ-1:0] enable_q, enable_d;
   logic [NIRQ-1:0] mode_q, mode_d;
   logic [NIRQ-1:0] pending_q, pending_d;
   logic [NIRQ-1:0] edge_set, w1c, ack_clr;
   logic [NIRQ-1:0] eligible, eligible_d;
   logic [IDW-1:0]  first_id;
   state_e          state_q;
   logic            int_req_q;
   logic [IDW-1:0]  int_id_q;
   logic            in_service_q;

   assign int_req    = int_req_q;
   assign int_id     = int_id_q;
   assign in_service = in_service_q;

   // Next-state of the config and pending registers; a new edge beats any clear
   always_comb begin
      enable_d = enable_q;
      mode_d   = mode_q;
      w1c      = '0;
      ack_clr  = '0;
      if (cfg_we && (cfg_addr == ADDR_ENABLE)) enable_d = cfg_wdata;
      if (cfg_we && (cfg_addr == ADDR_MODE))   mode_d   = cfg_wdata;
      if (cfg_we && (cfg_addr == ADDR_PENDING)) w1c     = cfg_wdata;
      if ((state_q == REQ) && int_ack) ack_clr[int_id_q] = 1'b1;
      edge_set  = sync2_q & ~sync3_q;
      pending_d = (mode_q & sync2_q)
                | (~mode_q & (edge_set | (pending_q & ~(w1c | ack_clr))));
   end

   // Eligibility now (for arbitration) and after this edge (for withdrawal)
   always_comb begin
      eligible   = pending_q & enable_q;
      eligible_d = pending_d & enable_d;
      first_id   = '0;
      for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
         if (eligible[i]) first_id = IDW'(i);
      end
   end

   // Synchroniser chain, edge-detect flop and configuration registers
   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         sync3_q   <= '0;
         enable_q  <= '0;
         mode_q    <= '0;
         pending_q <= '0;
      end else begin
         sync1_q   <= irq_in;
         sync2_q   <= sync1_q;
         sync3_q   <= sync2_q;
         enable_q  <= enable_d;
         mode_q    <= mode_d;
         pending_q <= pending_d;
      end
   end

   // Request/service state machine with registered outputs; no nesting
   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         int_req_q    <= 1'b0;
         int_id_q     <= '0;
         in_service_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|eligible) begin
                  state_q   <= REQ;
                  int_req_q <= 1'b1;
                  int_id_q  <= first_id;
               end
            end
            REQ: begin
               if (int_ack) begin
                  state_q      <= SERVICE;
                  int_req_q    <= 1'b0;
                  in_service_q <= 1'b1;
               end else if (!eligible_d[int_id_q]) begin
                  state_q   <= IDLE;
                  int_req_q <= 1'b0;
               end
            end
            SERVICE: begin
               if (eoi) begin
                  state_q      <= IDLE;
                  in_service_q <= 1'b0;
               end
            end
            default: begin
               state_q      <= IDLE;
               int_req_q    <= 1'b0;
               in_service_q <= 1'b0;
            end
         endcase
      end
   end

   // Combinational register read port
   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         ADDR_ENABLE:  cfg_rdata = enable_q;
         ADDR_PENDING: cfg_rdata = pending_q;
         ADDR_STATUS:  cfg_rdata = NIRQ'({state_q, int_id_q});
         ADDR_MODE:    cfg_rdata = mode_q;
         default:      cfg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: expected request IDs go into a queue,
// a negedge monitor pops one on every int_req rise; register/state checks are inline.
module tb_irq_controller;

   logic       ph1;
   logic       reset;
   logic [7:0] irq_in;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_wdata;
   logic [7:0] cfg_rdata;
   logic       int_req;
   logic [2:0] int_id;
   logic       int_ack;
   logic       eoi;
   logic       in_service;

   int checks = 0;
   int errors = 0;
   logic clk_en = 1'b1;
   logic req_prev = 1'b0;
   logic [2:0] exp_q[$];

   irq_controller #(.NIRQ(8), .IDW(3)) dut (
      .ph1(ph1), .reset(reset), .irq_in(irq_in),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_rdata(cfg_rdata), .int_req(int_req), .int_id(int_id),
      .int_ack(int_ack), .eoi(eoi), .in_service(in_service)
   );

   initial ph1 = 1'b0;
   always begin
      #5;
      if (clk_en) ph1 = ~ph1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge ph1);
      #1;
   endtask

   task automatic write(input logic [1:0] a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      tick(1);
      cfg_we = 1'b0; cfg_wdata = '0;
   endtask

   task automatic rd(input string name, input logic [1:0] a, input logic [7:0] exp);
      cfg_addr = a;
      #1;
      check(name, 32'(cfg_rdata), 32'(exp));
   endtask

   task automatic rd_state(input string name, input logic [1:0] exp);
      cfg_addr = 2'd2;
      #1;
      check(name, 32'(cfg_rdata[4:3]), 32'(exp));
   endtask

   // pin high for exactly one sampling edge (edge k); returns just after edge k
   task automatic pulse(input logic [7:0] m);
      irq_in = m;
      tick(1);
      irq_in = '0;
   endtask

   task automatic ack();
      int_ack = 1'b1; tick(1); int_ack = 1'b0;
   endtask

   task automatic end_irq();
      eoi = 1'b1; tick(1); eoi = 1'b0;
   endtask

   // Scoreboard monitor: each new request must carry the next expected ID
   initial begin
      forever begin
         @(negedge ph1);
         if (int_req && !req_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_req: got id %0d expected no request", int_id);
            end else begin
               logic [2:0] e;
               e = exp_q.pop_front();
               if (int_id !== e) begin
                  errors++;
                  $display("FAIL req_id: got %0d expected %0d", int_id, e);
               end
            end
         end
         req_prev = int_req;
      end
   end

   initial begin
      reset = 1'b0; irq_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      int_ack = 1'b0; eoi = 1'b0;
      #12;
      check("rst_int_req", 32'(int_req), 0);
      check("rst_in_service", 32'(in_service), 0);
      check("rst_int_id", 32'(int_id), 0);
      rd("rst_status", 2'd2, 8'h00);
      reset = 1'b1;
      tick(2);

      // 1: single edge on line 1
      write(2'd0, 8'h03);
      exp_q.push_back(3'd1);
      pulse(8'h02);
      tick(1); rd("t1_pend_k1", 2'd1, 8'h00);
      tick(1); rd("t1_pend_k2", 2'd1, 8'h02);
      check("t1_req_k2", 32'(int_req), 0);
      tick(1);
      check("t1_req_k3", 32'(int_req), 1);
      check("t1_id_k3", 32'(int_id), 1);
      rd("t1_status_req", 2'd2, 8'h09);
      ack();
      check("t1_req_ack", 32'(int_req), 0);
      check("t1_insvc_ack", 32'(in_service), 1);
      rd("t1_pend_ack", 2'd1, 8'h00);
      rd("t1_status_svc", 2'd2, 8'h11);
      end_irq();
      rd_state("t1_state_eoi", 2'd0);
      check("t1_insvc_eoi", 32'(in_service), 0);

      // 2: simultaneous edges, lowest index first
      exp_q.push_back(3'd0);
      exp_q.push_back(3'd1);
      pulse(8'h03);
      tick(3);
      check("t2_req0", 32'(int_req), 1);
      check("t2_id0", 32'(int_id), 0);
      ack();
      rd("t2_pend_ack", 2'd1, 8'h02);
      tick(2);
      check("t2_req_svc", 32'(int_req), 0);
      end_irq();
      check("t2_req_eoi", 32'(int_req), 0);
      tick(1);
      check("t2_req1", 32'(int_req), 1);
      check("t2_id1", 32'(int_id), 1);
      ack();
      end_irq();

      // 3: masked line becomes requested once enabled
      write(2'd0, 8'h01);
      pulse(8'h02);
      tick(2);
      rd("t3_pend", 2'd1, 8'h02);
      check("t3_req_masked", 32'(int_req), 0);
      tick(2);
      check("t3_req_masked2", 32'(int_req), 0);
      exp_q.push_back(3'd1);
      write(2'd0, 8'h03);
      check("t3_req_wr", 32'(int_req), 0);
      tick(1);
      check("t3_req_en", 32'(int_req), 1);
      check("t3_id_en", 32'(int_id), 1);

      // 4: same line fires again during its own handler
      ack();
      pulse(8'h02);
      tick(2);
      rd("t4_pend_svc", 2'd1, 8'h02);
      check("t4_req_svc", 32'(int_req), 0);
      check("t4_insvc", 32'(in_service), 1);
      tick(3);
      check("t4_req_svc2", 32'(int_req), 0);
      exp_q.push_back(3'd1);
      end_irq();
      check("t4_req_eoi", 32'(int_req), 0);
      tick(1);
      check("t4_req_again", 32'(int_req), 1);
      check("t4_id_again", 32'(int_id), 1);

      // 5: withdrawal by W1C, then W1C coincident with a new edge
      write(2'd1, 8'h02);
      check("t5_req_w1c", 32'(int_req), 0);
      rd_state("t5_state_w1c", 2'd0);
      rd("t5_pend_w1c", 2'd1, 8'h00);
      exp_q.push_back(3'd1);
      pulse(8'h02);
      tick(3);
      check("t5_req_rearm", 32'(int_req), 1);
      pulse(8'h02);
      tick(1);
      write(2'd1, 8'h02);
      check("t5_req_edge_wins", 32'(int_req), 1);
      rd("t5_pend_edge_wins", 2'd1, 8'h02);
      rd_state("t5_state_edge_wins", 2'd1);

      // 6: async reset mid-service with the clock stopped
      write(2'd3, 8'h80);
      ack();
      check("t6_insvc", 32'(in_service), 1);
      clk_en = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      check("t6_rst_req", 32'(int_req), 0);
      check("t6_rst_insvc", 32'(in_service), 0);
      check("t6_rst_id", 32'(int_id), 0);
      rd("t6_rst_enable", 2'd0, 8'h00);
      rd("t6_rst_pend", 2'd1, 8'h00);
      rd("t6_rst_status", 2'd2, 8'h00);
      rd("t6_rst_mode", 2'd3, 8'h00);
      reset = 1'b1;
      #1;
      clk_en = 1'b1;
      tick(1);
      pulse(8'h02);
      tick(4);
      rd("t6_pend_noen", 2'd1, 8'h02);
      check("t6_req_noen", 32'(int_req), 0);
      exp_q.push_back(3'd1);
      write(2'd0, 8'h02);
      tick(1);
      check("t6_req_en", 32'(int_req), 1);
      check("t6_id_en", 32'(int_id), 1);
      tick(2);

      check("queue_drained", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
